// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; data wins unless a waiting fetch was passed over STARVE_LIMIT times.
// Request to ack takes at least 2 cycles; m_* are held until m_ready, and each stage stalls until its own ack.
module mem_port_arbiter #(
  parameter int datasize     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                if_req,
  input  logic [datasize-1:0] if_addr,
  output logic [datasize-1:0] if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [datasize-1:0] d_addr,
  input  logic [datasize-1:0] d_wdata,
  output logic [datasize-1:0] d_rdata,
  output logic                d_ack,
  output logic                m_req,
  output logic                m_we,
  output logic [datasize-1:0] m_addr,
  output logic [datasize-1:0] m_wdata,
  input  logic [datasize-1:0] m_rdata,
  input  logic                m_ready,
  output logic                Stall_IF,
  output logic                Stall_MEM
);

  typedef enum logic [1:0] {IDLE, D_BUSY, F_BUSY} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       d_elig;
  logic       f_elig;
  logic       grant_f;
  logic       grant_d;

  // A request whose ack is showing this cycle is the one just served, not a new one.
  assign d_elig  = d_req & ~d_ack;
  assign f_elig  = if_req & ~if_ack;
  assign grant_f = f_elig & (~d_elig | (starve_cnt == LIMIT));
  assign grant_d = d_elig & ~grant_f;

  assign Stall_IF  = RST & if_req & ~if_ack;
  assign Stall_MEM = RST & d_req & ~d_ack;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= D_BUSY;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (f_elig && (starve_cnt != LIMIT))
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_f) begin
            state      <= F_BUSY;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            starve_cnt <= '0;
          end
        end
        D_BUSY: begin
          if (m_ready) begin
            state <= IDLE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            d_ack <= 1'b1;
            // Stores leave the last load value visible.
            if (!m_we)
              d_rdata <= m_rdata;
          end
        end
        F_BUSY: begin
          if (m_ready) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          if_req = 1'b0;
  logic [DW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [DW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready = 1'b0;
  logic          Stall_IF;
  logic          Stall_MEM;

  logic [31:0] mem [0:255];

  always #5 CLK = ~CLK;

  assign m_rdata = mem[m_addr[9:2]];

  mem_port_arbiter #(.datasize(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: who owns the port, what transaction it carries, and the visible results.
  int          owner;   // 0 free, 1 data, 2 fetch
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_we;
  int          starve;
  int          d_run;
  logic        e_if_ack;
  logic        e_d_ack;
  logic [31:0] e_if_rdata;
  logic [31:0] e_d_rdata;
  int          cyc = 0;
  int          if_ack_cyc = 0;
  int          d_ack_cyc = 0;
  bit          rand_drive = 0;
  bit          keep_busy = 0;

  task automatic model_reset();
    owner      = 0;
    starve     = 0;
    d_run      = 0;
    e_if_ack   = 1'b0;
    e_d_ack    = 1'b0;
    e_if_rdata = '0;
    e_d_rdata  = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'b0, w, 2'b00};
  endfunction

  task automatic random_drive();
    if (e_if_ack || (!if_req && (keep_busy || $urandom_range(0, 2) == 0))) begin
      if_req  = keep_busy ? 1'b1 : 1'($urandom_range(0, 1));
      if_addr = rand_addr();
    end
    if (e_d_ack || (!d_req && (keep_busy || $urandom_range(0, 2) == 0))) begin
      d_req   = keep_busy ? 1'b1 : 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = rand_addr();
      d_wdata = $urandom;
    end
    m_ready = ($urandom_range(0, 2) != 0);
  endtask

  // One clock: check stalls on the driven inputs, advance the reference over the edge, compare outputs.
  task automatic step();
    logic        s_if_req, s_d_req, s_d_we, s_ready, ef, ed, na_if, na_d;
    logic [31:0] s_if_addr, s_d_addr, s_d_wdata;
    #1;
    check("stall_if", 32'(Stall_IF), 32'(if_req & ~e_if_ack));
    check("stall_mem", 32'(Stall_MEM), 32'(d_req & ~e_d_ack));
    s_if_req = if_req; s_if_addr = if_addr;
    s_d_req = d_req; s_d_we = d_we; s_d_addr = d_addr; s_d_wdata = d_wdata;
    s_ready = m_ready;
    @(posedge CLK);
    #1;
    cyc++;
    na_if = 1'b0;
    na_d  = 1'b0;
    if (owner == 0) begin
      ed = s_d_req && !e_d_ack;
      ef = s_if_req && !e_if_ack;
      if (ed && !(ef && starve == LIMIT)) begin
        owner = 1; t_addr = s_d_addr; t_we = s_d_we; t_wdata = s_d_wdata;
        if (ef) begin
          starve = (starve < LIMIT) ? starve + 1 : LIMIT;
          d_run++;
        end
      end else if (ef) begin
        check("starve_run_bound", 32'(d_run <= LIMIT), 32'd1);
        owner = 2; t_addr = s_if_addr; t_we = 1'b0; starve = 0; d_run = 0;
      end
    end else if (s_ready) begin
      if (owner == 2) begin
        na_if = 1'b1; e_if_rdata = mem[t_addr[9:2]]; if_ack_cyc = cyc;
      end else begin
        na_d = 1'b1; d_ack_cyc = cyc;
        if (t_we) mem[t_addr[9:2]] = t_wdata;
        else      e_d_rdata = mem[t_addr[9:2]];
      end
      owner = 0;
    end
    e_if_ack = na_if;
    e_d_ack  = na_d;
    check("m_req", 32'(m_req), 32'(owner != 0));
    if (owner != 0) begin
      check("m_addr", m_addr, t_addr);
      check("m_we", 32'(m_we), 32'(t_we));
      if (owner == 1) check("m_wdata", m_wdata, t_wdata);
    end
    check("if_ack", 32'(if_ack), 32'(e_if_ack));
    check("d_ack", 32'(d_ack), 32'(e_d_ack));
    check("if_rdata", if_rdata, e_if_rdata);
    check("d_rdata", d_rdata, e_d_rdata);
    if (rand_drive) random_drive();
    else begin
      if (e_if_ack) if_req = 1'b0;
      if (e_d_ack)  d_req  = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_req"}, 32'(m_req), 32'd0);
    check({tag, "_m_we"}, 32'(m_we), 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_if_ack"}, 32'(if_ack), 32'd0);
    check({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    check({tag, "_stall_if"}, 32'(Stall_IF), 32'd0);
    check({tag, "_stall_mem"}, 32'(Stall_MEM), 32'd0);
  endtask

  initial begin
    logic [31:0] keep;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();

    // Reset state, with requests already raised so the stalls are seen gated.
    if_req = 1'b1; d_req = 1'b1;
    #2;
    check_all_zero("reset");
    if_req = 1'b0; d_req = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Idle port with m_ready high: nothing may start.
    m_ready = 1'b1;
    step();
    step();
    check("ready_idle_m_req", 32'(m_req), 32'd0);

    // Single fetch, memory ready on the first m_req cycle.
    mem[8'h10] = 32'h8C010004;
    if_req = 1'b1; if_addr = 32'h40;
    step();
    check("fetch_m_addr", m_addr, 32'h40);
    check("fetch_m_we", 32'(m_we), 32'd0);
    check("fetch_stall_busy", 32'(Stall_IF), 32'd1);
    step();
    check("fetch_ack", 32'(if_ack), 32'd1);
    check("fetch_rdata", if_rdata, 32'h8C010004);
    step();
    check("fetch_ack_pulse", 32'(if_ack), 32'd0);

    // Simultaneous fetch and load: data first, fetch granted at the d_ack edge.
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
    step();
    check("sim_first_grant", m_addr, 32'h100);
    step();
    check("sim_d_ack", 32'(d_ack), 32'd1);
    step();
    check("sim_second_grant", m_addr, 32'h80);
    step();
    check("sim_if_ack", 32'(if_ack), 32'd1);
    check("sim_no_bubble", 32'(if_ack_cyc - d_ack_cyc), 32'd2);
    step();

    // Store with three wait states.
    keep = d_rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    m_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("store_hold_addr", m_addr, 32'h200);
      check("store_hold_wdata", m_wdata, 32'hDEADBEEF);
    end
    m_ready = 1'b1;
    step();
    check("store_ack", 32'(d_ack), 32'd1);
    check("store_rdata_kept", d_rdata, keep);
    step();
    check("store_ack_pulse", 32'(d_ack), 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    step();
    check("store_readback", d_rdata, 32'hDEADBEEF);
    step();

    // Mid-access reset while a load waits on memory.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    if_req = 1'b1; if_addr = 32'h48;
    m_ready = 1'b0;
    step();
    step();
    check("rst_busy", 32'(m_req), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    d_req = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    m_ready = 1'b1;
    step();
    check("post_rst_grant", m_addr, 32'h48);
    step();
    check("post_rst_if_ack", 32'(if_ack), 32'd1);
    check("post_rst_no_d_ack", 32'(d_ack), 32'd0);
    step();

    // Both stages kept busy, then free-running random traffic.
    rand_drive = 1;
    keep_busy = 1;
    random_drive();
    repeat (400) step();
    keep_busy = 0;
    repeat (3000) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the pipelined MIPS core.
Grants one requester at a time and holds the memory request until the memory signals ready. Returns read data with a one-cycle acknowledge pulse.
Drives Stall_IF and Stall_MEM into the hazard logic so the pipeline freezes while a stage waits for the port.

Parameters:
datasize, 32, width of data and address buses
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits; legal range 1..15

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
if_req  input  1  fetch read request; held until if_ack
if_addr  input  datasize  fetch address
if_rdata  output  datasize  fetch read data; valid when if_ack=1
if_ack  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request; held until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  datasize  data address
d_wdata  input  datasize  store data
d_rdata  output  datasize  load data; valid when d_ack=1
d_ack  output  1  one-cycle completion pulse for data
m_req  output  1  memory request
m_we  output  1  memory write enable
m_addr  output  datasize  memory address
m_wdata  output  datasize  memory write data
m_rdata  input  datasize  memory read data; valid with m_ready
m_ready  input  1  memory completion; sampled only while m_req=1
Stall_IF  output  1  fetch stage must hold
Stall_MEM  output  1  memory stage must hold

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - m_req, m_we, if_ack, d_ack = 0.
  - m_addr, m_wdata, if_rdata, d_rdata = 0.
  - Starvation counter = 0.
  - An in-flight access is abandoned and no ack is issued.
- States: IDLE, D_BUSY, F_BUSY.
- IDLE, at the clock edge:
  - Eligible requests are d_req and if_req, each masked by its own ack being 1 in that cycle. A requester sees its ack at the edge and drops or renews its request after that edge.
  - Selection: data wins, unless if_req is eligible and the counter equals STARVE_LIMIT; then fetch wins.
  - On a grant, m_req, m_we (d_we for data, 0 for fetch), m_addr and m_wdata are registered from the winner's inputs.
  - m_req is high from the cycle after the grant edge. There is no combinational path from requests to m_*.
- D_BUSY / F_BUSY:
  - m_req, m_we, m_addr and m_wdata stay constant; requester input changes are ignored.
  - At the edge where m_ready=1:
    - m_req and m_we go to 0.
    - For a fetch or a load, m_rdata is captured into if_rdata or d_rdata.
    - The matching ack goes high for exactly one cycle.
    - State returns to IDLE.
  - Minimum latency is 2 cycles from request to ack (memory ready in the first m_req cycle).
  - Wait states are unbounded; there is no timeout.
- The ack cycle is the IDLE cycle, so a new grant can occur at the ack edge. The other requester can be granted back-to-back with no bubble.
- A store updates no rdata register; d_rdata keeps its last load value.
- if_rdata and d_rdata hold their values between acks.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req is eligible.
  - Clears on any fetch grant.
  - Holds otherwise.
- Stall_IF = if_req & ~if_ack; Stall_MEM = d_req & ~d_ack. Both are combinational and 0 in reset.
- The acknowledged requester is always the same as the granted one: a fetch grant never completes with d_ack, and a data grant never completes with if_ack.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000040, memory ready in the 1st m_req cycle with m_rdata=0x8C010004 -> m_addr=0x40 and m_we=0; if_ack pulses 2 cycles after the request with if_rdata=0x8C010004; Stall_IF=1 until the ack cycle.
- Simultaneous requests: if_req and d_req (load, 0x100) asserted in the same cycle -> data granted first, d_ack, then fetch granted at the d_ack edge; if_ack follows with no idle cycle.
- Store with 3 wait states: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, m_ready high on the 4th m_req cycle -> m_* held constant for 4 cycles, d_ack pulses once, d_rdata unchanged.
- Starvation: d_req held continuously (renewed each ack) while if_req=1, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then the counter restarts.
- Mid-access reset: RST low for 1 cycle while in D_BUSY -> all outputs 0 immediately, no d_ack; after release, a pending if_req is served normally.
- Ready outside a request: m_ready=1 while m_req=0 -> no state change, no ack.
